// File: rtl/car_alarm_fsm.sv
// car_alarm_fsm: anti-theft controller with arm/entry/siren timers.
// All timing runs from a 1 Hz tick edge-detected in the 50 MHz domain.
`timescale 1ns/1ps
module car_alarm_fsm #(
  parameter int T_ARM   = 6,
  parameter int T_ENTRY = 8,
  parameter int T_ALARM = 10,
  parameter int CNT_W   = 4
) (
  input  logic             clk_fiftymhz,
  input  logic             rst,
  input  logic             clk_onehz,
  input  logic             ignition,
  input  logic             door,
  input  logic             hidden_sw,
  input  logic             brake,
  output logic             siren,
  output logic             status_led,
  output logic             armed,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] sec_left
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARM_WAIT = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_ARM = CNT_W'(T_ARM);
  localparam logic [CNT_W-1:0] LD_ENTRY = CNT_W'(T_ENTRY);
  localparam logic [CNT_W-1:0] LD_ALARM = CNT_W'(T_ALARM);

  logic [1:0] ign_q;
  logic [1:0] door_q;
  logic [1:0] hid_q;
  logic [1:0] brk_q;
  logic       onehz_q;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;
  logic [CNT_W-1:0] timer_dec;

  logic siren_q;
  logic siren_d;
  logic armed_q;
  logic armed_d;
  logic led_q;
  logic led_d;

  logic ign_s;
  logic door_s;
  logic tick;
  logic expire;
  logic disarm;

  assign ign_s  = ign_q[1];
  assign door_s = door_q[1];
  assign disarm = ign_q[1] & hid_q[1] & brk_q[1];

  // onehz_q resets high, so a high clk_onehz at release is not a tick
  assign tick   = clk_onehz & ~onehz_q;
  assign expire = tick & (timer_q == ONE);

  always_comb begin
    timer_dec = timer_q;
    if (tick && (timer_q > ONE)) begin
      timer_dec = timer_q - ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_dec;
    if ((state_q != S_DISARMED) && disarm) begin
      state_d = S_DISARMED;
      timer_d = '0;
    end else begin
      case (state_q)
        S_DISARMED: begin
          timer_d = '0;
          if (!ign_s && !door_s) begin
            state_d = S_ARM_WAIT;
            timer_d = LD_ARM;
          end
        end
        S_ARM_WAIT: begin
          if (ign_s) begin
            state_d = S_DISARMED;
            timer_d = '0;
          end else if (door_s) begin
            timer_d = LD_ARM;
          end else if (expire) begin
            state_d = S_ARMED;
            timer_d = '0;
          end
        end
        S_ARMED: begin
          timer_d = '0;
          if (ign_s) begin
            state_d = S_ALARM;
            timer_d = LD_ALARM;
          end else if (door_s) begin
            state_d = S_ENTRY;
            timer_d = LD_ENTRY;
          end
        end
        S_ENTRY: begin
          if (expire) begin
            state_d = S_ALARM;
            timer_d = LD_ALARM;
          end
        end
        S_ALARM: begin
          if (expire && door_s) begin
            timer_d = LD_ALARM;
          end else if (expire) begin
            state_d = S_ARMED;
            timer_d = '0;
          end
        end
        default: begin
          state_d = S_DISARMED;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    siren_d = (state_d == S_ALARM);
    armed_d = (state_d == S_ARMED)
            | (state_d == S_ENTRY)
            | (state_d == S_ALARM);
    led_d   = 1'b0;
    unique case (1'b1)
      (state_d == S_ARM_WAIT),
      (state_d == S_ENTRY): led_d = 1'b1;
      (state_d == S_ARMED),
      (state_d == S_ALARM): led_d = clk_onehz;
      default:              led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_fiftymhz or posedge rst) begin
    if (rst) begin
      ign_q   <= '0;
      door_q  <= '0;
      hid_q   <= '0;
      brk_q   <= '0;
      onehz_q <= 1'b1;
      state_q <= S_DISARMED;
      timer_q <= '0;
      siren_q <= 1'b0;
      armed_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      ign_q   <= {ign_q[0], ignition};
      door_q  <= {door_q[0], door};
      hid_q   <= {hid_q[0], hidden_sw};
      brk_q   <= {brk_q[0], brake};
      onehz_q <= clk_onehz;
      state_q <= state_d;
      timer_q <= timer_d;
      siren_q <= siren_d;
      armed_q <= armed_d;
      led_q   <= led_d;
    end
  end

  assign siren      = siren_q;
  assign armed      = armed_q;
  assign status_led = led_q;
  assign state      = state_q;
  assign sec_left   = timer_q;

endmodule
